// File: rtl/cache_instrucoes_refill.sv
// Direct-mapped instruction cache with a built-in line-refill engine.
// Sits between the IF stage and instruction memory. On a miss it stalls the
// pipeline, fetches the whole line one word per beat over a req/ack port,
// marks the line valid and resumes. A one-cycle flush invalidates every line.
//
// Ports
//   clock                     system clock, rising edge
//   reset_n                   asynchronous reset, active low
//   PC                        fetch address (PC[1:0] ignored)
//   flush                     invalidate all lines, aborts a refill in flight
//   stall_cache_instrucoes    1 = instruction not available, hold PC
//   instrucao_do_processador  fetched instruction, 0 while stalled
//   mem_req / mem_addr        refill beat request and its word-aligned address
//   mem_ack / mem_rdata       beat accepted, data valid in the same cycle
//
// FSM states
//   state    | meaning
//   S_IDLE   | serving hits; a miss latches the line and starts a refill
//   S_REFILL | requesting beats of the latched line until the last one is acked

module cache_instrucoes_refill #(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 2,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] PC,
  input  logic                  flush,
  output logic                  stall_cache_instrucoes,
  output logic [31:0]           instrucao_do_processador,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
  localparam int OFF_BITS  = WORD_BITS + 2;
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS  = ADDR_WIDTH - IDX_BITS - OFF_BITS;
  localparam int WSEL_BITS = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam logic [WSEL_BITS-1:0] LAST_BEAT = WSEL_BITS'(WORDS_PER_LINE - 1);

  typedef enum logic {
    S_IDLE,
    S_REFILL
  } state_t;

  state_t state_q, next_state;

  logic [TAG_BITS-1:0]  pc_tag;
  logic [IDX_BITS-1:0]  pc_index;
  logic [WSEL_BITS-1:0] pc_word;

  logic [TAG_BITS-1:0]  lat_tag_q;
  logic [IDX_BITS-1:0]  lat_index_q;
  logic [WSEL_BITS-1:0] beat_q;
  logic [NUM_LINES-1:0] valid_q;

  logic [TAG_BITS-1:0] tag_array  [NUM_LINES];
  logic [31:0]         data_array [NUM_LINES][WORDS_PER_LINE];

  logic hit;
  logic start_refill;
  logic beat_write;
  logic line_done;
  logic unused_pc_bits;

  assign pc_tag         = PC[ADDR_WIDTH-1 -: TAG_BITS];
  assign pc_index       = PC[OFF_BITS +: IDX_BITS];
  assign unused_pc_bits = ^PC[1:0];

  generate
    if (WORD_BITS > 0) begin : g_multi_word
      assign pc_word  = PC[2 +: WORD_BITS];
      assign mem_addr = {lat_tag_q, lat_index_q, beat_q, 2'b00};
    end else begin : g_single_word
      assign pc_word  = '0;
      assign mem_addr = {lat_tag_q, lat_index_q, 2'b00};
    end
  endgenerate

  assign hit = valid_q[pc_index] && (tag_array[pc_index] == pc_tag);

  assign stall_cache_instrucoes   = (state_q != S_IDLE) || !hit;
  assign instrucao_do_processador = stall_cache_instrucoes ? 32'h0
                                                           : data_array[pc_index][pc_word];
  assign mem_req = (state_q == S_REFILL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= next_state;
  end

  // flush wins over both miss detection and last-beat completion; an ack
  // arriving together with flush is dropped.
  always_comb begin
    next_state   = state_q;
    start_refill = 1'b0;
    beat_write   = 1'b0;
    line_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && !hit) begin
          start_refill = 1'b1;
          next_state   = S_REFILL;
        end
      end
      S_REFILL: begin
        if (flush) begin
          next_state = S_IDLE;
        end else if (mem_ack) begin
          beat_write = 1'b1;
          if (beat_q == LAST_BEAT) begin
            line_done  = 1'b1;
            next_state = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      lat_tag_q   <= '0;
      lat_index_q <= '0;
      beat_q      <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end else if (start_refill) begin
        // cleared at the miss so a partially written line can never hit
        valid_q[pc_index] <= 1'b0;
      end else if (line_done) begin
        valid_q[lat_index_q] <= 1'b1;
      end

      if (start_refill) begin
        lat_tag_q   <= pc_tag;
        lat_index_q <= pc_index;
        beat_q      <= '0;
      end else if (beat_write) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // Arrays carry no reset: their contents are don't-care while invalid.
  always_ff @(posedge clock) begin
    if (beat_write) data_array[lat_index_q][beat_q] <= mem_rdata;
    if (line_done)  tag_array[lat_index_q]          <= lat_tag_q;
  end

endmodule
